// File: rtl/core_run_ctrl_pkg.sv
// Shared types and constants for the core run controller.
package core_run_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CLEAR,
        ST_RUN,
        ST_DONE
    } run_state_e;

    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] ECALL  = 32'h0000_0073;

endpackage

// File: rtl/run_watchdog.sv
// RUN-cycle watchdog compare; only built when CORE_RUN_CTRL_WATCHDOG_EN is defined.
`ifdef CORE_RUN_CTRL_WATCHDOG_EN
module run_watchdog #(
    parameter int MAX_CYCLES = 100000
) (
    input  logic        run_i,
    input  logic [31:0] cycle_count_i,
    output logic        expired_o
);

    localparam logic [31:0] LIMIT = 32'(MAX_CYCLES - 1);

    assign expired_o = run_i && (cycle_count_i == LIMIT);

endmodule
`endif

// File: rtl/core_run_ctrl.sv
// Program loader and run sequencer for a simple core.
// Optional watchdog timeout enabled by defining CORE_RUN_CTRL_WATCHDOG_EN.
module core_run_ctrl
    import core_run_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int MAX_CYCLES = 100000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  load_valid,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_last,
    output logic                  load_ready,
    input  logic [DATA_WIDTH-1:0] instr,
    output logic                  imem_wr_en,
    output logic [ADDR_WIDTH-1:0] imem_wr_addr,
    output logic [DATA_WIDTH-1:0] imem_wr_data,
    output logic                  core_rst,
    output logic                  core_run,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout,
    output logic                  overflow,
    output logic [31:0]           cycle_count
);

    run_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           cycle_q, cycle_d;
    logic                  overflow_q, overflow_d;
    logic                  halt;
    logic                  wd_expired;
    logic                  start_ok;

    assign halt     = (instr == DATA_WIDTH'(EBREAK)) || (instr == DATA_WIDTH'(ECALL));
    assign start_ok = start && !abort && ((state_q == ST_IDLE) || (state_q == ST_DONE));

`ifdef CORE_RUN_CTRL_WATCHDOG_EN
    logic timeout_q;

    run_watchdog #(
        .MAX_CYCLES(MAX_CYCLES)
    ) u_watchdog (
        .run_i        (state_q == ST_RUN),
        .cycle_count_i(cycle_q),
        .expired_o    (wd_expired)
    );

    // A halt in the same cycle wins: the run ends normally, not by timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_q <= 1'b0;
        end else if (start_ok) begin
            timeout_q <= 1'b0;
        end else if (!abort && wd_expired && !halt) begin
            timeout_q <= 1'b1;
        end
    end

    assign timeout = timeout_q;
`else
    logic unused_max_cycles;

    assign unused_max_cycles = ^32'(MAX_CYCLES);
    assign wd_expired        = 1'b0;
    assign timeout           = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cycle_d    = cycle_q;
        overflow_d = overflow_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d    = ST_LOAD;
                    addr_d     = '0;
                    cycle_d    = '0;
                    overflow_d = 1'b0;
                end
            end
            ST_LOAD: begin
                if (load_valid) begin
                    // The counter parks on the last address instead of wrapping.
                    if (addr_q != '1) begin
                        addr_d = addr_q + 1'b1;
                    end
                    if (load_last) begin
                        state_d = ST_CLEAR;
                    end else if (addr_q == '1) begin
                        state_d    = ST_CLEAR;
                        overflow_d = 1'b1;
                    end
                end
            end
            ST_CLEAR: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (cycle_q != '1) begin
                    cycle_d = cycle_q + 32'd1;
                end
                if (halt || wd_expired) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort) begin
            state_d    = ST_IDLE;
            addr_d     = addr_q;
            cycle_d    = cycle_q;
            overflow_d = overflow_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            cycle_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cycle_q    <= cycle_d;
            overflow_q <= overflow_d;
        end
    end

    assign load_ready   = (state_q == ST_LOAD);
    assign imem_wr_en   = load_valid && load_ready;
    assign imem_wr_addr = addr_q;
    assign imem_wr_data = load_data;
    assign core_rst     = (state_q == ST_IDLE) || (state_q == ST_LOAD) || (state_q == ST_CLEAR);
    assign core_run     = (state_q == ST_RUN);
    assign busy         = (state_q == ST_LOAD) || (state_q == ST_CLEAR) || (state_q == ST_RUN);
    assign done         = (state_q == ST_DONE);
    assign overflow     = overflow_q;
    assign cycle_count  = cycle_q;

endmodule

// File: tb/tb_core_run_ctrl.sv
// Directed self-checking bench for core_run_ctrl (depth 4, watchdog limit 8).
module tb_core_run_ctrl;

    localparam int DW = 32;
    localparam int AW = 2;
    localparam int MC = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic          load_valid;
    logic [DW-1:0] load_data;
    logic          load_last;
    logic          load_ready;
    logic [DW-1:0] instr;
    logic          imem_wr_en;
    logic [AW-1:0] imem_wr_addr;
    logic [DW-1:0] imem_wr_data;
    logic          core_rst;
    logic          core_run;
    logic          busy;
    logic          done;
    logic          timeout;
    logic          overflow;
    logic [31:0]   cycle_count;

    int unsigned vec_cnt = 0;
    int unsigned err_cnt = 0;

    core_run_ctrl #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .MAX_CYCLES(MC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_last   (load_last),
        .load_ready  (load_ready),
        .instr       (instr),
        .imem_wr_en  (imem_wr_en),
        .imem_wr_addr(imem_wr_addr),
        .imem_wr_data(imem_wr_data),
        .core_rst    (core_rst),
        .core_run    (core_run),
        .busy        (busy),
        .done        (done),
        .timeout     (timeout),
        .overflow    (overflow),
        .cycle_count (cycle_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        load_last  = 1'b0;
        instr      = '0;
        tick();
        tick();
        check("rst_core_rst", 32'(core_rst), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ready", 32'(load_ready), 32'd0);
        check("rst_core_run", 32'(core_run), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_cycles", cycle_count, 32'd0);
        check("rst_addr", 32'(imem_wr_addr), 32'd0);
        rst = 1'b0;
        tick();

        // Load three words, then halt on the 5th RUN cycle.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("ld_ready", 32'(load_ready), 32'd1);
        check("ld_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 3; i++) begin
            load_valid = 1'b1;
            load_data  = 32'hA000_0000 + 32'(i);
            load_last  = (i == 2);
            #1;
            check("ld_wr_en", 32'(imem_wr_en), 32'd1);
            check("ld_addr", 32'(imem_wr_addr), 32'(i));
            check("ld_data", imem_wr_data, 32'hA000_0000 + 32'(i));
            tick();
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        check("clr_core_rst", 32'(core_rst), 32'd1);
        check("clr_core_run", 32'(core_run), 32'd0);
        check("clr_ready", 32'(load_ready), 32'd0);
        tick();
        check("run_core_run", 32'(core_run), 32'd1);
        check("run_core_rst", 32'(core_rst), 32'd0);
        for (int i = 0; i < 4; i++) tick();
        instr = 32'h0010_0073;
        tick();
        instr = '0;
        check("halt_done", 32'(done), 32'd1);
        check("halt_cycles", cycle_count, 32'd5);
        check("halt_core_rst", 32'(core_rst), 32'd0);
        check("halt_core_run", 32'(core_run), 32'd0);
        tick();
        check("done_hold", cycle_count, 32'd5);

        // Load with a stall bubble, then halt via ECALL.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("st_cycles_clr", cycle_count, 32'd0);
        load_valid = 1'b1;
        load_data  = 32'hB0;
        #1;
        check("st_en0", 32'(imem_wr_en), 32'd1);
        check("st_addr0", 32'(imem_wr_addr), 32'd0);
        tick();
        load_valid = 1'b0;
        #1;
        check("st_en_idle", 32'(imem_wr_en), 32'd0);
        tick();
        load_valid = 1'b1;
        load_data  = 32'hB1;
        load_last  = 1'b1;
        #1;
        check("st_en1", 32'(imem_wr_en), 32'd1);
        check("st_addr1", 32'(imem_wr_addr), 32'd1);
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
        tick();
        instr = 32'h0000_0073;
        tick();
        instr = '0;
        check("ecall_done", 32'(done), 32'd1);
        check("ecall_cycles", cycle_count, 32'd1);

        // Overflow: five words offered into a 4-deep memory.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            load_valid = 1'b1;
            load_data  = 32'hC0 + 32'(i);
            #1;
            check("ov_en", 32'(imem_wr_en), 32'd1);
            check("ov_addr", 32'(imem_wr_addr), 32'(i));
            tick();
        end
        load_last = 1'b1;
        #1;
        check("ov_ready", 32'(load_ready), 32'd0);
        check("ov_en5", 32'(imem_wr_en), 32'd0);
        check("ov_flag", 32'(overflow), 32'd1);
        check("ov_core_rst", 32'(core_rst), 32'd1);
        check("ov_addr_hold", 32'(imem_wr_addr), 32'd3);
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
        check("ov_run", 32'(core_run), 32'd1);

        // Watchdog: eight RUN cycles with no halt.
        for (int i = 0; i < 8; i++) tick();
        check("wd_cycles", cycle_count, 32'd8);
`ifdef CORE_RUN_CTRL_WATCHDOG_EN
        check("wd_done", 32'(done), 32'd1);
        check("wd_timeout", 32'(timeout), 32'd1);
`else
        check("wd_done", 32'(done), 32'd0);
        check("wd_still_run", 32'(core_run), 32'd1);
        check("wd_timeout", 32'(timeout), 32'd0);
`endif
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab_idle_rst", 32'(core_rst), 32'd1);
        check("ab_idle_busy", 32'(busy), 32'd0);
        check("ab_ov_keep", 32'(overflow), 32'd1);
        check("ab_cyc_keep", cycle_count, 32'd8);

        // Start ignored in RUN; abort beats start mid-RUN.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("rs_ov_clr", 32'(overflow), 32'd0);
        check("rs_to_clr", 32'(timeout), 32'd0);
        load_valid = 1'b1;
        load_last  = 1'b1;
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("run_start_ign", 32'(core_run), 32'd1);
        check("run_cyc1", cycle_count, 32'd1);
        tick();
        tick();
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        check("abst_core_rst", 32'(core_rst), 32'd1);
        check("abst_busy", 32'(busy), 32'd0);
        check("abst_ready", 32'(load_ready), 32'd0);
        check("abst_cycles", cycle_count, 32'd3);

        // Reset mid-LOAD, then restart from address 0.
        start = 1'b1;
        tick();
        start = 1'b0;
        load_valid = 1'b1;
        load_data  = 32'hD0;
        tick();
        check("rl_addr1", 32'(imem_wr_addr), 32'd1);
        rst   = 1'b1;
        start = 1'b1;
        tick();
        #1;
        check("rl_ready", 32'(load_ready), 32'd0);
        check("rl_en", 32'(imem_wr_en), 32'd0);
        check("rl_addr", 32'(imem_wr_addr), 32'd0);
        check("rl_core_rst", 32'(core_rst), 32'd1);
        check("rl_busy", 32'(busy), 32'd0);
        rst        = 1'b0;
        load_valid = 1'b0;
        tick();
        start = 1'b0;
        load_valid = 1'b1;
        load_data  = 32'hE0;
        #1;
        check("rl_re_en", 32'(imem_wr_en), 32'd1);
        check("rl_re_addr", 32'(imem_wr_addr), 32'd0);
        tick();
        load_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
